avl_resp_shim: RTL and testbench

Return-path shim between the DDR3 Avalon-MM read port and the NoC injection interface of the simple frame buffer. Avalon `readdatavalid` cannot be back-pressured while the NoC can stall, so the block meters outstanding reads with a credit counter, stores each read's return tag at issue, and buffers read data. Each read response leaves as one 4-flit NoC packet carrying the data and its tag.

---
 rtl/avl_resp_shim.sv | 81 ++++++++
 tb/tb_avl_resp_shim.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/avl_resp_shim.sv
// rtl/avl_resp_shim.sv - Avalon read-return to NoC shim with credit metering, tag FIFO and response FIFO
module avl_resp_shim #(
    parameter int AVL_DATA_WIDTH = 512,
    parameter int TAG_WIDTH      = 32,
    parameter int WIDTH_PKT      = AVL_DATA_WIDTH + 1 + 1 + TAG_WIDTH,
    parameter int DEPTH          = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rd_issue_in,
    input  logic [TAG_WIDTH-1:0]      rd_tag_in,
    output logic                      rd_allow_out,
    input  logic [AVL_DATA_WIDTH-1:0] avl_readdata_in,
    input  logic                      avl_readdatavalid_in,
    output logic [WIDTH_PKT-1:0]      noc_data_out,
    output logic [3:0]                noc_valid_out,
    output logic [3:0]                noc_sop_out,
    output logic [3:0]                noc_eop_out,
    input  logic                      noc_ready_in,
    output logic                      err_out
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [CW-1:0]         cnt;
    logic [TAG_WIDTH-1:0]  tag_mem [DEPTH];
    logic [WIDTH_PKT-1:0]  resp_mem [DEPTH];
    logic [AW:0]           tag_wr, tag_rd, resp_wr, resp_rd;
    logic                  tag_empty, resp_empty;
    logic                  noc_pop, issue_ok, tag_pop, err_set;
    logic [AW-1:0]         last_idx;

    assign tag_empty    = (tag_wr == tag_rd);
    assign resp_empty   = (resp_wr == resp_rd);
    assign rd_allow_out = (cnt < CW'(DEPTH));
    assign noc_pop      = ~resp_empty & noc_ready_in;
    // A pop in the same cycle frees a credit, so an issue at full credit is still legal then.
    assign issue_ok     = rd_issue_in & (rd_allow_out | noc_pop);
    assign tag_pop      = avl_readdatavalid_in & ~tag_empty;
    assign err_set      = (rd_issue_in & ~issue_ok) | (avl_readdatavalid_in & tag_empty);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            tag_wr  <= '0;
            tag_rd  <= '0;
            resp_wr <= '0;
            resp_rd <= '0;
            err_out <= 1'b0;
        end else begin
            cnt <= cnt + CW'(issue_ok) - CW'(noc_pop);
            if (issue_ok) tag_wr <= tag_wr + 1'b1;
            if (tag_pop) begin
                tag_rd  <= tag_rd + 1'b1;
                resp_wr <= resp_wr + 1'b1;
            end
            if (noc_pop) resp_rd <= resp_rd + 1'b1;
            if (err_set) err_out <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (issue_ok) tag_mem[tag_wr[AW-1:0]] <= rd_tag_in;
    end

    // Response storage is reset so the idle data output reads as zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) resp_mem[i] <= '0;
        end else if (tag_pop) begin
            resp_mem[resp_wr[AW-1:0]] <= {tag_mem[tag_rd[AW-1:0]], 1'b0, 1'b1, avl_readdata_in};
        end
    end

    // When empty, the slot just behind the read pointer is the last packet sent.
    assign last_idx      = resp_rd[AW-1:0] - 1'b1;
    assign noc_data_out  = resp_empty ? resp_mem[last_idx] : resp_mem[resp_rd[AW-1:0]];
    assign noc_valid_out = {4{~resp_empty}};
    assign noc_sop_out   = {3'b000, ~resp_empty};
    assign noc_eop_out   = {~resp_empty, 3'b000};
endmodule

// File: tb/tb_avl_resp_shim.sv
// tb/tb_avl_resp_shim.sv - directed and randomized bench for avl_resp_shim against a queue model
module tb_avl_resp_shim;
    localparam int DW = 512;
    localparam int TW = 32;
    localparam int WP = DW + 2 + TW;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rd_issue_in = 1'b0;
    logic [TW-1:0] rd_tag_in = '0;
    logic          rd_allow_out;
    logic [DW-1:0] avl_readdata_in = '0;
    logic          avl_readdatavalid_in = 1'b0;
    logic [WP-1:0] noc_data_out;
    logic [3:0]    noc_valid_out, noc_sop_out, noc_eop_out;
    logic          noc_ready_in = 1'b0;
    logic          err_out;

    int checks = 0;
    int errors = 0;

    int            m_cnt = 0;
    logic          m_err = 1'b0;
    logic [TW-1:0] tagq[$];
    logic [WP-1:0] respq[$];

    avl_resp_shim #(.AVL_DATA_WIDTH(DW), .TAG_WIDTH(TW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_issue_in(rd_issue_in), .rd_tag_in(rd_tag_in), .rd_allow_out(rd_allow_out),
        .avl_readdata_in(avl_readdata_in), .avl_readdatavalid_in(avl_readdatavalid_in),
        .noc_data_out(noc_data_out), .noc_valid_out(noc_valid_out),
        .noc_sop_out(noc_sop_out), .noc_eop_out(noc_eop_out),
        .noc_ready_in(noc_ready_in), .err_out(err_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WP-1:0] obs, input logic [WP-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic check_state();
        logic ne;
        ne = (respq.size() > 0);
        check("valid", WP'(noc_valid_out), ne ? WP'(4'hF) : WP'(0));
        check("sop", WP'(noc_sop_out), ne ? WP'(4'h1) : WP'(0));
        check("eop", WP'(noc_eop_out), ne ? WP'(4'h8) : WP'(0));
        if (ne) check("data", noc_data_out, respq[0]);
        check("allow", WP'(rd_allow_out), WP'(m_cnt < DEPTH));
        check("err", WP'(err_out), WP'(m_err));
        check("cnt", WP'(dut.cnt), WP'(m_cnt));
    endtask

    // One clock cycle: drive inputs, check registered state, advance the model at the edge.
    task automatic step(input logic iss, input logic [TW-1:0] tg, input logic rdv,
                        input logic [DW-1:0] d, input logic rdy);
        logic pop, acc;
        logic [TW-1:0] t;
        rd_issue_in = iss;
        rd_tag_in = tg;
        avl_readdatavalid_in = rdv;
        avl_readdata_in = d;
        noc_ready_in = rdy;
        #1;
        check_state();
        pop = (respq.size() > 0) && rdy;
        acc = iss && ((m_cnt < DEPTH) || pop);
        if (iss && !acc) m_err = 1'b1;
        if (pop) void'(respq.pop_front());
        if (rdv) begin
            if (tagq.size() > 0) begin
                t = tagq.pop_front();
                respq.push_back({t, 1'b0, 1'b1, d});
            end else m_err = 1'b1;
        end
        if (acc) tagq.push_back(tg);
        m_cnt = m_cnt + int'(acc) - int'(pop);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, '0, 1'b0, '0, rdy);
    endtask

    task automatic issue(input logic [TW-1:0] tg, input logic rdy);
        step(1'b1, tg, 1'b0, '0, rdy);
    endtask

    task automatic ret(input logic rdy);
        step(1'b0, '0, 1'b1, rand_data(), rdy);
    endtask

    task automatic model_clear();
        m_cnt = 0;
        m_err = 1'b0;
        tagq.delete();
        respq.delete();
    endtask

    task automatic drain();
        for (int i = 0; i < 3 * DEPTH && (tagq.size() > 0 || respq.size() > 0); i++) begin
            if (tagq.size() > 0) ret(1'b1);
            else idle(1'b1);
        end
    endtask

    task automatic mid_reset();
        #2 rst_n = 1'b0;
        rd_issue_in = 1'b0;
        avl_readdatavalid_in = 1'b0;
        noc_ready_in = 1'b0;
        #1;
        check("rst_valid", WP'(noc_valid_out), WP'(0));
        check("rst_sop", WP'(noc_sop_out), WP'(0));
        check("rst_eop", WP'(noc_eop_out), WP'(0));
        check("rst_allow", WP'(rd_allow_out), WP'(1));
        check("rst_err", WP'(err_out), WP'(0));
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset values
        #1;
        check("reset_valid", WP'(noc_valid_out), WP'(0));
        check("reset_data", noc_data_out, WP'(0));
        check("reset_allow", WP'(rd_allow_out), WP'(1));
        check("reset_err", WP'(err_out), WP'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single read
        issue(32'h0000_00A5, 1'b0);
        for (int i = 0; i < 4; i++) idle(1'b0);
        step(1'b0, '0, 1'b1, DW'(16'h1234), 1'b0);
        check("single_pkt", noc_data_out, {32'h0000_00A5, 1'b0, 1'b1, DW'(16'h1234)});
        check("single_valid", WP'(noc_valid_out), WP'(4'hF));
        check("single_cnt", WP'(dut.cnt), WP'(1));
        idle(1'b1);
        check("single_popped", WP'(noc_valid_out), WP'(0));
        check("single_cnt0", WP'(dut.cnt), WP'(0));

        // Credit limit
        for (int i = 0; i < DEPTH; i++) issue(32'h100 + i, 1'b0);
        check("credit_allow0", WP'(rd_allow_out), WP'(0));
        for (int i = 0; i < DEPTH; i++) ret(1'b0);
        check("credit_still0", WP'(rd_allow_out), WP'(0));
        idle(1'b1);
        check("credit_allow1", WP'(rd_allow_out), WP'(1));
        drain();

        // Back-pressure with three queued responses
        for (int i = 0; i < 3; i++) issue(32'h200 + i, 1'b0);
        for (int i = 0; i < 3; i++) ret(1'b0);
        idle(1'b0); idle(1'b1); idle(1'b0); idle(1'b1); idle(1'b1);
        check("bp_empty", WP'(noc_valid_out), WP'(0));

        // Issue and pop together at full credit
        for (int i = 0; i < DEPTH; i++) issue(32'h300 + i, 1'b0);
        ret(1'b0);
        issue(32'h3FF, 1'b1);
        check("simul_cnt", WP'(dut.cnt), WP'(DEPTH));
        check("simul_err", WP'(err_out), WP'(0));
        drain();

        // Readdatavalid without an outstanding tag
        ret(1'b0);
        check("err_orphan", WP'(err_out), WP'(1));
        idle(1'b0);
        check("err_sticky", WP'(err_out), WP'(1));
        mid_reset();

        // Issue while credit exhausted
        for (int i = 0; i < DEPTH; i++) issue(32'h400 + i, 1'b0);
        issue(32'h4FF, 1'b0);
        check("err_overissue", WP'(err_out), WP'(1));
        check("err_cnt", WP'(dut.cnt), WP'(DEPTH));
        drain();

        // Reset mid-stream with four queued responses
        for (int i = 0; i < 4; i++) issue(32'h500 + i, 1'b0);
        for (int i = 0; i < 4; i++) ret(1'b0);
        mid_reset();
        for (int i = 0; i < 3; i++) idle(1'b1);
        check("rst_nostale", WP'(noc_valid_out), WP'(0));

        // Randomized legal traffic
        for (int i = 0; i < 800; i++) begin
            logic iss, rdv;
            iss = ($urandom_range(0, 1) == 1) && (m_cnt < DEPTH);
            rdv = ($urandom_range(0, 2) != 0) && (tagq.size() > 0);
            step(iss, $urandom, rdv, rand_data(), $urandom_range(0, 2) != 0);
        end
        drain();
        idle(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
